// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, defaults and index helper for the FFT reorder stage
// Purpose: default sizes, complex sample type, bank/read state enums and the
//          bit-reversal helper used by fft_bitrev_reorder.
// Ports:   none (package).
package fft_pkg;

  localparam int N_LOG2_DEF = 10;
  localparam int DATA_W_DEF = 23;
  // Widest index the bit-reversal helper supports.
  localparam int IDX_W_MAX  = 16;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_e;

  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

  // Reverses the low n_log2 bits of idx. Bits are shifted out LSB-first and
  // in from the right, so idx[0] lands at position n_log2-1.
  function automatic logic [IDX_W_MAX-1:0] bitrev(input logic [IDX_W_MAX-1:0] idx,
                                                  input int n_log2);
    logic [IDX_W_MAX-1:0] r;
    logic [IDX_W_MAX-1:0] t;
    r = '0;
    t = idx;
    for (int i = 0; i < IDX_W_MAX; i++) begin
      if (i < n_log2) begin
        r = {r[IDX_W_MAX-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - simple dual-port frame RAM for the reorder stage
// Purpose: holds both ping-pong banks; address = {bank, idx}. One write port,
//          one read port with 1-cycle synchronous read.
// Ports:   clk      clock
//          we_i     write enable, waddr_i/wdata_i write address/data
//          re_i     read enable, raddr_i read address
//          rdata_o  read data, valid the cycle after re_i
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int ADDR_W = N_LOG2_DEF + 1,
  parameter int WIDTH  = 2 * DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - bit-reversed to natural order frame reorder with ping-pong buffer
// Purpose: stores each N-point FFT frame (arriving in bit-reversed bin order)
//          in one of two banks and replays it in natural order through a
//          2-entry output skid buffer with ready/valid backpressure.
// Config:  FFT_REORDER_OVF_EN adds the sticky ovf_o frame-drop flag.
// Ports:   clk, rst (sync, active-high)
//          data_re_i/data_im_i/valid_i  input samples, bit-reversed order
//          data_re_o/data_im_o/valid_o  output samples, natural order
//          ready_i                      downstream accept
//          sof_o/eof_o                  bin 0 / bin N-1 markers
//          ovf_o                        sticky drop flag (optional)
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_re_i,
  input  logic [DATA_W-1:0] data_im_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_re_o,
  output logic [DATA_W-1:0] data_im_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sof_o,
`ifdef FFT_REORDER_OVF_EN
  output logic              eof_o,
  output logic              ovf_o
`else
  output logic              eof_o
`endif
);

  localparam int ENT_W = 2 * DATA_W + 2;
  localparam logic [N_LOG2-1:0] IDX_LAST = '1;

  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              drop_q, drop_d;
  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic              pend_q, pend_sof_q, pend_eof_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [ENT_W-1:0]  ent_q [2];
  logic [ENT_W-1:0]  ent_d [2];

  logic              drop_now, wr_en, rd_en, pop, can_read;
  logic [N_LOG2-1:0] wr_idx;
  logic [2:0]        occ;
  logic [2*DATA_W-1:0] ram_rdata;

`ifdef FFT_REORDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_o = ovf_q;
`endif

  assign wr_idx   = N_LOG2'(bitrev(IDX_W_MAX'(wr_cnt_q), N_LOG2));
  // The drop decision is taken on bin 0 and then held for the whole frame.
  assign drop_now = (wr_cnt_q == '0) ? (bank_q[wr_bank_q] != EMPTY) : drop_q;
  assign wr_en    = valid_i && !drop_now;

  // A read may be issued only if its data still fits once the in-flight read
  // has landed and this cycle's pop has left.
  assign pop      = (cnt_q != 2'd0) && ready_i;
  assign occ      = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
  assign can_read = occ < 3'd2;

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    bank_d     = bank_q;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    rd_en      = 1'b0;
`ifdef FFT_REORDER_OVF_EN
    ovf_d      = ovf_q;
`endif

    if (valid_i) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '0) begin
        drop_d = drop_now;
        if (!drop_now) begin
          bank_d[wr_bank_q] = FILL;
        end
`ifdef FFT_REORDER_OVF_EN
        if (drop_now) begin
          ovf_d = 1'b1;
        end
`endif
      end
      // A dropped frame leaves wr_bank alone so written banks keep strictly
      // alternating, which is the order the reader drains them in.
      if (wr_cnt_q == IDX_LAST && !drop_now) begin
        bank_d[wr_bank_q] = FULL;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // rd_cnt_q is 0 whenever the reader is idle, so the first read of a bank
    // can go out in the same cycle the FULL bank is seen.
    if (can_read && (rd_state_q == RD_DRAIN || bank_q[rd_bank_q] == FULL)) begin
      rd_en = 1'b1;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_q[rd_bank_q] == FULL) begin
          rd_state_d        = RD_DRAIN;
          bank_d[rd_bank_q] = DRAIN;
        end
      end
      default: ;
    endcase

    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == IDX_LAST) begin
        bank_d[rd_bank_q] = EMPTY;
        rd_bank_d         = ~rd_bank_q;
        rd_state_d        = RD_IDLE;
      end
    end
  end

  // Skid buffer: entry 0 is the head driving the outputs. Pushes only arrive
  // when at most one entry remains after the pop, so cnt_d[0] is the slot.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (pend_q) begin
      ent_d[cnt_d[0]] = {pend_sof_q, pend_eof_q, ram_rdata};
      cnt_d           = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      pend_q     <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eof_q <= 1'b0;
      cnt_q      <= 2'd0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
`ifdef FFT_REORDER_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      drop_q     <= drop_d;
      bank_q     <= bank_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= rd_en;
      pend_sof_q <= (rd_cnt_q == '0);
      pend_eof_q <= (rd_cnt_q == IDX_LAST);
      cnt_q      <= cnt_d;
      ent_q      <= ent_d;
`ifdef FFT_REORDER_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  fft_pingpong_ram #(
    .ADDR_W (N_LOG2 + 1),
    .WIDTH  (2 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_idx}),
    .wdata_i ({data_re_i, data_im_i}),
    .re_i    (rd_en),
    .raddr_i ({rd_bank_q, rd_cnt_q}),
    .rdata_o (ram_rdata)
  );

  assign valid_o   = (cnt_q != 2'd0);
  assign sof_o     = valid_o && ent_q[0][ENT_W-1];
  assign eof_o     = valid_o && ent_q[0][ENT_W-2];
  assign data_re_o = ent_q[0][2*DATA_W-1:DATA_W];
  assign data_im_o = ent_q[0][DATA_W-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder (N_LOG2=3)
module tb_fft_bitrev_reorder;

  localparam int NL = 3;
  localparam int N  = 8;
  localparam int DW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_re_i, data_im_i, data_re_o, data_im_o;
  logic          valid_i, ready_i, valid_o, sof_o, eof_o;
`ifdef FFT_REORDER_OVF_EN
  logic          ovf;
`endif

  fft_bitrev_reorder #(.N_LOG2(NL), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_re_i (data_re_i),
    .data_im_i (data_im_i),
    .valid_i   (valid_i),
    .data_re_o (data_re_o),
    .data_im_o (data_im_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sof_o     (sof_o),
`ifdef FFT_REORDER_OVF_EN
    .eof_o     (eof_o),
    .ovf_o     (ovf)
`else
    .eof_o     (eof_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            out_cnt, first_cyc, last_cyc, last_in_cyc;
  bit            rnd_ready = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_re, prev_im, first_re, first_im, last_re, last_im;
  logic          first_sof, last_eof;

  function automatic int model_bitrev(input int k);
    int r = 0;
    for (int b = 0; b < NL; b++)
      if (((k >> b) & 1) == 1) r = r | (1 << (NL - 1 - b));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_stats();
    out_cnt   = 0;
    first_cyc = -1;
    last_cyc  = -1;
  endtask

  // Frame f carries value 16*f+bin in re and its negation in im, presented in
  // bit-reversed bin order; a kept full frame is expected back in bin order.
  task automatic feed(input int f, input int nsamp, input bit gap, input bit keep);
    for (int k = 0; k < nsamp; k++) begin
      int n;
      n         = model_bitrev(k);
      data_re_i = DW'(16 * f + n);
      data_im_i = DW'(-(16 * f + n));
      valid_i   = 1'b1;
      last_in_cyc = cyc;
      tick();
      if (gap) begin
        valid_i = 1'b0;
        tick();
      end
    end
    valid_i = 1'b0;
    if (keep && nsamp == N) begin
      for (int n = 0; n < N; n++) begin
        exp_t e;
        e.re  = DW'(16 * f + n);
        e.im  = DW'(-(16 * f + n));
        e.sof = (n == 0);
        e.eof = (n == N - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_out(input string name, input int target, input int budget);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, out_cnt, target);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_sof"}, sof_o, 0);
    chk({tag, "_eof"}, eof_o, 0);
    chk({tag, "_re"}, data_re_o, 0);
    chk({tag, "_im"}, data_im_o, 0);
`ifdef FFT_REORDER_OVF_EN
    chk({tag, "_ovf"}, ovf, 0);
`endif
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", valid_o, 1);
          chk("hold_re", data_re_o, prev_re);
          chk("hold_im", data_im_o, prev_im);
        end
        if (valid_o) begin
          if (first_cyc < 0) begin
            first_cyc = cyc;
            first_re  = data_re_o;
            first_im  = data_im_o;
            first_sof = sof_o;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_out", valid_o, 0);
          end else begin
            chk("out_re", data_re_o, exp_q[0].re);
            chk("out_im", data_im_o, exp_q[0].im);
            chk("out_sof", sof_o, exp_q[0].sof);
            chk("out_eof", eof_o, exp_q[0].eof);
            if (ready_i) begin
              void'(exp_q.pop_front());
              out_cnt++;
              last_cyc = cyc;
              last_re  = data_re_o;
              last_im  = data_im_o;
              last_eof = eof_o;
            end
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_re    = data_re_o;
        prev_im    = data_im_o;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    data_re_i = '0;
    data_im_i = '0;
    clear_stats();
    fork
      compare_loop();
    join_none

    chk("pin_bitrev1", model_bitrev(1), 4);
    chk("pin_bitrev6", model_bitrev(6), 3);

    repeat (3) tick();
    @(negedge clk);
    check_reset("rst0");
    tick();
    rst = 1'b0;
    tick();

    // 1: one frame back-to-back
    clear_stats();
    feed(0, N, 1'b0, 1'b1);
    wait_out("t1_count", N, 100);
    chk("t1_latency", first_cyc - last_in_cyc, 3);
    chk("t1_first_re", first_re, 0);
    chk("t1_first_im", first_im, 0);
    chk("t1_first_sof", first_sof, 1);
    chk("t1_last_re", last_re, 7);
    chk("t1_last_im", last_im, 23'h7FFFF9);
    chk("t1_last_eof", last_eof, 1);
    repeat (4) tick();

    // 2: same frame, valid on alternate cycles
    clear_stats();
    feed(0, N, 1'b1, 1'b1);
    wait_out("t2_count", N, 100);
    chk("t2_latency", first_cyc - last_in_cyc, 3);
    chk("t2_last_re", last_re, 7);
    repeat (4) tick();

    // 3: four frames back-to-back, output must be gapless
    clear_stats();
    for (int f = 1; f <= 4; f++) feed(f, N, 1'b0, 1'b1);
    wait_out("t3_count", 4 * N, 200);
    chk("t3_gapless", last_cyc - first_cyc, 4 * N - 1);
`ifdef FFT_REORDER_OVF_EN
    chk("t3_ovf", ovf, 0);
`endif
    repeat (4) tick();

    // 4: ready low through three frames; third frame is dropped
    clear_stats();
    ready_i = 1'b0;
    feed(5, N, 1'b0, 1'b1);
    feed(6, N, 1'b0, 1'b1);
    feed(7, N, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t4_stalled_cnt", out_cnt, 0);
    chk("t4_valid_held", valid_o, 1);
`ifdef FFT_REORDER_OVF_EN
    chk("t4_ovf", ovf, 1);
`endif
    ready_i = 1'b1;
    wait_out("t4_count", 2 * N, 200);
    repeat (20) tick();
    chk("t4_total", out_cnt, 2 * N);
    chk("t4_first_re", first_re, 80);
    chk("t4_last_re", last_re, 103);

    // 5: random backpressure over two frames
    clear_stats();
    rnd_ready = 1;
    feed(8, N, 1'b0, 1'b1);
    feed(9, N, 1'b0, 1'b1);
    wait_out("t5_count", 2 * N, 600);
    rnd_ready = 0;
    ready_i   = 1'b1;
    repeat (6) tick();
    chk("t5_last_re", last_re, 16 * 9 + 7);

    // 6: reset in the middle of a frame
    clear_stats();
    feed(10, 5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset("rst_mid");
    tick();
    exp_q.delete();
    rst = 1'b0;
    clear_stats();
    tick();
    feed(11, N, 1'b0, 1'b1);
    wait_out("t6_count", N, 100);
    chk("t6_latency", first_cyc - last_in_cyc, 3);
    chk("t6_first_re", first_re, 176);
    chk("t6_first_sof", first_sof, 1);
    repeat (10) tick();
    chk("t6_total", out_cnt, N);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
